// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, round-key index width, RCON constants,
// S-box and word helpers (also used by the cipher datapath), and the key
// schedule FSM state type.
package aes_pkg;

  localparam int AES_ROUNDS = 10;
  localparam int RK_IDX_W   = 4;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} ksState_e;

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  function automatic logic [31:0] rotWord(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Multiply by x in GF(2^8); advances rcon one round.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key-expansion round, purely combinational.
// Ports: prevKey - previous round key (word 0 in MSBs)
//        rcon    - round constant for this round
//        nextKey - next round key
module aes_key_round_step
  import aes_pkg::*;
(
  input  logic [127:0] prevKey,
  input  logic [7:0]   rcon,
  output logic [127:0] nextKey
);

  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  always_comb begin
    w0 = prevKey[127:96];
    w1 = prevKey[95:64];
    w2 = prevKey[63:32];
    w3 = prevKey[31:0];
    t  = subWord(rotWord(w3)) ^ {rcon, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    nextKey = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128 key-schedule controller. Accepts a cipher key over
// key_valid/key_ready, runs one expansion round per cycle into an 11-entry
// round-key buffer, and serves round keys through a registered read port.
// Optional macro AES_KEY_ZEROIZE_EN adds a zeroize input that clears the
// buffer one slot per cycle and holds the controller idle.
// Ports: clk, reset (async, active-high); key_in/key_valid/key_ready key
// handshake; busy, done (1-cycle pulse), keys_valid status; rd_idx/rd_en
// read request, rd_key/rd_hit registered read response.
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_ROUNDS,
  parameter int KEY_W      = 128
) (
  input  logic                clk,
  input  logic                reset,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic [KEY_W-1:0]    key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic [RK_IDX_W-1:0] rd_idx,
  input  logic                rd_en,
  output logic [KEY_W-1:0]    rd_key,
  output logic                rd_hit
);

  localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NUM_ROUNDS);

  ksState_e            state, stateNext;
  logic [RK_IDX_W-1:0] round, prevIdx, wrIdx;
  logic [7:0]          rcon;
  logic                keysValid, doneQ, rdHit, accept, lastRound, zeroActive, wrEn;
  logic [KEY_W-1:0]    rdKey, stepKey, wrData;
  logic [KEY_W-1:0]    slot [NUM_ROUNDS+1];

`ifdef AES_KEY_ZEROIZE_EN
  logic [RK_IDX_W-1:0] zeroCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                zeroCnt <= '0;
    else if (!zeroize)        zeroCnt <= '0;
    else if (zeroCnt <= LAST_IDX) zeroCnt <= zeroCnt + 4'd1;
  end

  assign zeroActive = zeroize;
`else
  assign zeroActive = 1'b0;
`endif

  assign lastRound = (round == LAST_IDX);
  // The previous round key is read back from the buffer itself.
  assign prevIdx   = (round == '0) ? '0 : round - 4'd1;

  aes_key_round_step uStep (
    .prevKey (slot[prevIdx]),
    .rcon    (rcon),
    .nextKey (stepKey)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    key_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE, READY: begin
        key_ready = !zeroActive;
        accept    = key_valid && key_ready;
        if (accept) stateNext = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (lastRound) stateNext = READY;
      end
      default: stateNext = IDLE;
    endcase
    if (zeroActive) stateNext = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round     <= '0;
      rcon      <= RCON_INIT;
      keysValid <= 1'b0;
      doneQ     <= 1'b0;
      rdKey     <= '0;
      rdHit     <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (zeroActive) begin
        keysValid <= 1'b0;
      end else if (accept) begin
        round     <= 4'd1;
        rcon      <= RCON_INIT;
        keysValid <= 1'b0;
      end else if (state == EXPAND) begin
        round <= lastRound ? '0 : round + 4'd1;
        rcon  <= xtime(rcon);
        if (lastRound) begin
          doneQ     <= 1'b1;
          keysValid <= 1'b1;
        end
      end

      // Reads sample keysValid before this edge, so a read in the
      // acceptance cycle still sees the old schedule.
      if (rd_en) begin
        if (rd_idx <= LAST_IDX && keysValid && !zeroActive) begin
          rdKey <= slot[rd_idx];
          rdHit <= 1'b1;
        end else begin
          rdKey <= '0;
          rdHit <= 1'b0;
        end
      end else begin
        rdHit <= 1'b0;
      end
    end
  end

  always_comb begin
    wrEn   = 1'b0;
    wrIdx  = '0;
    wrData = '0;
    if (accept) begin
      wrEn   = 1'b1;
      wrData = key_in;
    end else if (state == EXPAND) begin
      wrEn   = 1'b1;
      wrIdx  = round;
      wrData = stepKey;
    end
`ifdef AES_KEY_ZEROIZE_EN
    if (zeroize) begin
      wrEn   = (zeroCnt <= LAST_IDX);
      wrIdx  = zeroCnt;
      wrData = '0;
    end
`endif
  end

  // Buffer has no reset; keys_valid gates all visibility.
  always_ff @(posedge clk) begin
    if (wrEn && wrIdx <= LAST_IDX) slot[wrIdx] <= wrData;
  end

  assign done       = doneQ;
  assign keys_valid = keysValid;
  assign rd_key     = rdKey;
  assign rd_hit     = rdHit;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
module tb_aes_key_schedule_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready, busy, done, keys_valid, rd_hit;
  logic [3:0]   rd_idx = '0;
  logic         rd_en = 1'b0;
  logic [127:0] rd_key;
`ifdef AES_KEY_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  aes_key_schedule_ctrl #(.NUM_ROUNDS(10), .KEY_W(128)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_en      (rd_en),
    .rd_key     (rd_key),
    .rd_hit     (rd_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: S-box from GF(2^8) inverse + affine map, textbook
  // word-based key expansion, and a cycle-count view of the controller.
  logic [7:0] mSbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] modelRoundKey(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {mSbox[t[31:24]], mSbox[t[23:16]], mSbox[t[15:8]], mSbox[t[7:0]]};
        t[31:24] ^= rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  int           mRemain = 0;
  logic         mKeysValid = 0, mDone = 0, mRdHit = 0, mZer = 0, mAcc = 0;
  logic [127:0] mRdKey = '0;
  logic [127:0] mSched [11];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mRemain = 0; mKeysValid = 0; mDone = 0; mRdHit = 0; mRdKey = '0;
    end else begin
      mZer = 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
      mZer = zeroize;
`endif
      mAcc = key_valid && (mRemain == 0) && !mZer;
      if (rd_en) begin
        if (rd_idx <= 4'd10 && mKeysValid && !mZer) begin
          mRdHit = 1; mRdKey = mSched[rd_idx];
        end else begin
          mRdHit = 0; mRdKey = '0;
        end
      end else begin
        mRdHit = 0;
      end
      mDone = 0;
      if (mZer) begin
        mRemain = 0; mKeysValid = 0;
      end else if (mAcc) begin
        mRemain = 10; mKeysValid = 0;
        for (int r = 0; r < 11; r++) mSched[r] = modelRoundKey(key_in, r);
      end else if (mRemain > 0) begin
        mRemain--;
        if (mRemain == 0) begin mDone = 1; mKeysValid = 1; end
      end
    end
  end

  // Per-cycle comparison, 2 time units after each rising edge.
  always @(posedge clk) begin
    logic expReady;
    #2;
    expReady = (mRemain == 0);
`ifdef AES_KEY_ZEROIZE_EN
    if (zeroize && !reset) expReady = 1'b0;
`endif
    chk("busy", busy, mRemain != 0);
    chk("done", done, mDone);
    chk("keys_valid", keys_valid, mKeysValid);
    chk("key_ready", key_ready, expReady);
    chk("rd_hit", rd_hit, mRdHit);
    chk("rd_key", rd_key, mRdKey);
  end

  task automatic sendKey(input logic [127:0] k);
    logic wasReady, ok;
    ok = 0;
    @(negedge clk);
    key_in = k; key_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      wasReady = key_ready;
      @(posedge clk);
      if (wasReady) ok = 1;
      else @(negedge clk);
    end
    chk("accept_timeout", ok, 1'b1);
  endtask

  task automatic waitDone();
    logic seen;
    seen = 0;
    @(negedge clk);
    key_valid = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(posedge clk); #2;
      if (done) seen = 1;
    end
    chk("done_timeout", seen, 1'b1);
  endtask

  task automatic readKey(input logic [3:0] idx, input string name,
                         input logic [127:0] expKey, input logic expHit);
    @(negedge clk);
    rd_en = 1'b1; rd_idx = idx;
    @(posedge clk); #2;
    chk({name, "_key"}, rd_key, expKey);
    chk({name, "_hit"}, rd_hit, expHit);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int busyCnt, doneCnt, doneAt;
    logic [7:0] inv;

    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      mSbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    chk("model_fips_rk1", modelRoundKey(FIPS_KEY, 1), FIPS_RK1);
    chk("model_fips_rk10", modelRoundKey(FIPS_KEY, 10), FIPS_RK10);
    chk("model_zero_rk10", modelRoundKey('0, 10), ZERO_RK10);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #2;
    chk("reset_key_ready", key_ready, 1'b1);
    chk("reset_keys_valid", keys_valid, 1'b0);

    // Latency, busy width, and key_valid held during busy.
    sendKey(FIPS_KEY);
    busyCnt = 0; doneCnt = 0; doneAt = -1;
    for (int i = 0; i < 15; i++) begin
      #2;
      if (busy) busyCnt++;
      if (done) begin doneCnt++; doneAt = i; end
      @(negedge clk);
      key_valid = (i < 8);
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      rd_en = 1'($urandom_range(0, 1));
      rd_idx = 4'($urandom_range(0, 15));
      @(posedge clk);
    end
    @(negedge clk);
    key_valid = 1'b0; rd_en = 1'b0;
    chk("busy_cycles", 128'(busyCnt), 128'd10);
    chk("done_pulses", 128'(doneCnt), 128'd1);
    chk("done_offset", 128'(doneAt), 128'd10);

    readKey(4'd1, "fips_idx1", FIPS_RK1, 1'b1);
    readKey(4'd10, "fips_idx10", FIPS_RK10, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("hold_rd_key", rd_key, FIPS_RK10);
    chk("hold_rd_hit", rd_hit, 1'b0);
    readKey(4'd0, "fips_idx0", FIPS_KEY, 1'b1);
    readKey(4'd11, "idx11", '0, 1'b0);
    readKey(4'd15, "idx15", '0, 1'b0);

    // Re-key with zeros while reading the old schedule in the same cycle.
    @(negedge clk);
    key_in = '0; key_valid = 1'b1; rd_en = 1'b1; rd_idx = 4'd10;
    @(posedge clk); #2;
    chk("rekey_old_read", rd_key, FIPS_RK10);
    chk("rekey_old_hit", rd_hit, 1'b1);
    chk("rekey_kv_drop", keys_valid, 1'b0);
    @(negedge clk);
    rd_en = 1'b0;
    waitDone();
    readKey(4'd10, "zero_idx10", ZERO_RK10, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      key_valid = ($urandom_range(0, 7) == 0);
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      rd_en = 1'($urandom_range(0, 1));
      rd_idx = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    key_valid = 1'b0; rd_en = 1'b0;

    // Reset during round 5.
    sendKey(FIPS_KEY);
    repeat (4) @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_keys_valid", keys_valid, 1'b0);
    chk("abort_rd_hit", rd_hit, 1'b0);
    chk("abort_rd_key", rd_key, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sendKey(FIPS_KEY);
    waitDone();
    readKey(4'd10, "post_abort_idx10", FIPS_RK10, 1'b1);

`ifdef AES_KEY_ZEROIZE_EN
    @(negedge clk);
    zeroize = 1'b1;
    repeat (11) @(posedge clk);
    #2;
    chk("zeroize_keys_valid", keys_valid, 1'b0);
    chk("zeroize_key_ready", key_ready, 1'b0);
    @(negedge clk);
    zeroize = 1'b0;
    sendKey(FIPS_KEY);
    waitDone();
    readKey(4'd10, "post_zeroize_idx10", FIPS_RK10, 1'b1);
`endif

    repeat (2) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
